// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with a 2-bit saturating direction counter
// per entry. Combinational lookup of the fetch PC and registered training from execute.
module branch_predictor #(
  parameter int PC_WIDTH = 32,
  parameter int ENTRIES  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lookup_valid,
  input  logic [PC_WIDTH-1:0] lookup_pc,
  output logic                predict_take_branch,
  output logic [PC_WIDTH-1:0] predict_target_pc_in,
  input  logic                upd_valid,
  input  logic [PC_WIDTH-1:0] upd_pc,
  input  logic                upd_taken,
  input  logic [PC_WIDTH-1:0] upd_target,
  output logic [31:0]         hit_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_WIDTH - IDX_W - 2;

  localparam logic [1:0] CTR_STRONG_NT = 2'b00;
  localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
  localparam logic [1:0] CTR_WEAK_T    = 2'b10;
  localparam logic [1:0] CTR_STRONG_T  = 2'b11;

  typedef struct packed {
    logic                valid;
    logic [TAG_W-1:0]    tag;
    logic [PC_WIDTH-1:0] target;
    logic [1:0]          ctr;
  } entry_t;

  localparam entry_t ENTRY_RESET = '{
    valid:  1'b0,
    tag:    '0,
    target: '0,
    ctr:    CTR_WEAK_NT
  };

  entry_t btb_q [ENTRIES];

  // Address decode; the two byte-offset bits never participate.
  logic [IDX_W-1:0] lookup_idx, upd_idx;
  logic [TAG_W-1:0] lookup_tag, upd_tag;
  logic             unused_offset_bits;

  assign lookup_idx         = lookup_pc[IDX_W+1:2];
  assign lookup_tag         = lookup_pc[PC_WIDTH-1:IDX_W+2];
  assign upd_idx            = upd_pc[IDX_W+1:2];
  assign upd_tag            = upd_pc[PC_WIDTH-1:IDX_W+2];
  assign unused_offset_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

  // Lookup path. Reset masks the outputs so fetch never redirects while the
  // array is still being cleared.
  entry_t lookup_entry;
  logic   hit;

  assign lookup_entry = btb_q[lookup_idx];
  assign hit = lookup_valid && !rst && lookup_entry.valid &&
               (lookup_entry.tag == lookup_tag);

  assign predict_take_branch  = hit && lookup_entry.ctr[1];
  assign predict_target_pc_in = rst ? '0 : lookup_entry.target;

  // Training path: next value of the entry selected by the resolved branch.
  entry_t upd_entry;
  entry_t upd_entry_next;
  logic   upd_hit;
  logic   upd_write;

  assign upd_entry = btb_q[upd_idx];
  assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    upd_entry_next = upd_entry;
    upd_write      = 1'b0;
    if (upd_valid) begin
      if (upd_hit) begin
        upd_write = 1'b1;
        if (upd_taken) begin
          upd_entry_next.target = upd_target;
          if (upd_entry.ctr != CTR_STRONG_T)
            upd_entry_next.ctr = upd_entry.ctr + 2'd1;
        end else if (upd_entry.ctr != CTR_STRONG_NT) begin
          upd_entry_next.ctr = upd_entry.ctr - 2'd1;
        end
      end else if (upd_taken) begin
        // Allocate or replace the aliased entry; not-taken misses never allocate.
        upd_write      = 1'b1;
        upd_entry_next = '{
          valid:  1'b1,
          tag:    upd_tag,
          target: upd_target,
          ctr:    CTR_WEAK_T
        };
      end
    end
  end

  // NOTE: the BTB array is explicitly reset (not left as uninitialised RAM)
  // because every entry must come up invalid with a weak-not-taken counter.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample pre-edge values; this is also what gives lookups no update bypass.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) btb_q[i] <= ENTRY_RESET;
      hit_count <= '0;
    end else begin
      if (upd_write) btb_q[upd_idx] <= upd_entry_next;
      if (hit) hit_count <= hit_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor: stimulus pushes expected
// lookup responses into a queue; a negedge monitor pops and compares them.
module tb_branch_predictor;

  localparam int PC_WIDTH = 32;
  localparam int ENTRIES  = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                lookup_valid;
  logic [PC_WIDTH-1:0] lookup_pc;
  logic                predict_take_branch;
  logic [PC_WIDTH-1:0] predict_target_pc_in;
  logic                upd_valid;
  logic [PC_WIDTH-1:0] upd_pc;
  logic                upd_taken;
  logic [PC_WIDTH-1:0] upd_target;
  logic [31:0]         hit_count;

  branch_predictor #(.PC_WIDTH(PC_WIDTH), .ENTRIES(ENTRIES)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .lookup_valid         (lookup_valid),
    .lookup_pc            (lookup_pc),
    .predict_take_branch  (predict_take_branch),
    .predict_target_pc_in (predict_target_pc_in),
    .upd_valid            (upd_valid),
    .upd_pc               (upd_pc),
    .upd_taken            (upd_taken),
    .upd_target           (upd_target),
    .hit_count            (hit_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        take;
    logic        chk_tgt;
    logic [31:0] tgt;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q [$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: one expected record per presented lookup, sampled mid-cycle.
  always @(negedge clk) begin
    if (lookup_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_lookup: got lookup of 0x%08h expected none", lookup_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, ".take"}, {31'd0, predict_take_branch}, {31'd0, e.take});
        check({e.name, ".hit_count"}, hit_count, e.cnt);
        if (e.chk_tgt) check({e.name, ".target"}, predict_target_pc_in, e.tgt);
      end
    end
  end

  // One cycle of stimulus; inputs change 1 time unit after the rising edge.
  task automatic step(input string name,
                      input logic r, input logic lv, input logic [31:0] lpc,
                      input logic uv, input logic [31:0] upc, input logic ut,
                      input logic [31:0] utgt,
                      input logic e_take, input logic e_chk_tgt,
                      input logic [31:0] e_tgt, input logic [31:0] e_cnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst          = r;
    lookup_valid = lv;
    lookup_pc    = lpc;
    upd_valid    = uv;
    upd_pc       = upc;
    upd_taken    = ut;
    upd_target   = utgt;
    if (lv) begin
      e.name    = name;
      e.take    = e_take;
      e.chk_tgt = e_chk_tgt;
      e.tgt     = e_tgt;
      e.cnt     = e_cnt;
      exp_q.push_back(e);
    end
  endtask

  task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    step("upd", 1'b0, 1'b0, 32'h0, 1'b1, pc, t, tgt, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic look(input string name, input logic [31:0] pc, input logic e_take,
                      input logic e_chk_tgt, input logic [31:0] e_tgt, input logic [31:0] e_cnt);
    step(name, 1'b0, 1'b1, pc, 1'b0, 32'h0, 1'b0, 32'h0, e_take, e_chk_tgt, e_tgt, e_cnt);
  endtask

  initial begin
    rst = 1'b1; lookup_valid = 1'b0; lookup_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;

    // Reset: outputs held at zero while rst is high.
    step("reset0", 1'b1, 1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step("in_reset", 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0);

    // Post-reset miss with cleared target.
    look("post_reset", 32'h100, 1'b0, 1'b1, 32'h0, 32'h0);

    // Allocate on taken; same-cycle lookup sees pre-update state.
    step("alloc_nobypass", 1'b0, 1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h200,
         1'b0, 1'b0, 32'h0, 32'h0);
    look("alloc_hit", 32'h100, 1'b1, 1'b1, 32'h200, 32'h0);              // ctr 10, cnt->1

    // Saturation: 10 -> 11 (x3 stays 11) -> NT 10.
    upd(32'h100, 1'b1, 32'h200);
    upd(32'h100, 1'b1, 32'h200);
    upd(32'h100, 1'b1, 32'h200);
    upd(32'h100, 1'b0, 32'h0);
    look("sat_weak_taken", 32'h100, 1'b1, 1'b1, 32'h200, 32'h1);        // cnt->2
    upd(32'h100, 1'b0, 32'h0);                                           // 01
    look("weak_not_taken", 32'h100, 1'b0, 1'b0, 32'h0, 32'h2);          // hit, cnt->3
    upd(32'h100, 1'b0, 32'h0);                                           // 00
    upd(32'h100, 1'b0, 32'h0);                                           // stays 00
    look("strong_not_taken", 32'h100, 1'b0, 1'b0, 32'h0, 32'h3);        // cnt->4
    upd(32'h100, 1'b1, 32'h240);                                         // 01, target 0x240
    look("nt_after_one_taken", 32'h100, 1'b0, 1'b0, 32'h0, 32'h4);      // cnt->5
    upd(32'h100, 1'b1, 32'h240);                                         // 10
    look("retrained_target", 32'h100, 1'b1, 1'b1, 32'h240, 32'h5);      // cnt->6

    // No allocation on not-taken miss (0x300 aliases index 0, tag differs).
    upd(32'h300, 1'b0, 32'h999);
    look("no_alloc_nt", 32'h300, 1'b0, 1'b0, 32'h0, 32'h6);
    look("entry_kept", 32'h100, 1'b1, 1'b1, 32'h240, 32'h6);            // cnt->7

    // lookup_valid low: no prediction, no count.
    step("lv_low", 1'b0, 1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    look("lv_low_after", 32'h100, 1'b1, 1'b1, 32'h240, 32'h7);          // cnt->8

    // Alias replacement with same-cycle collision.
    step("alias_collide", 1'b0, 1'b1, 32'h140, 1'b1, 32'h140, 1'b1, 32'h400,
         1'b0, 1'b0, 32'h0, 32'h8);
    look("alias_old_miss", 32'h100, 1'b0, 1'b0, 32'h0, 32'h8);
    look("alias_new_hit", 32'h140, 1'b1, 1'b1, 32'h400, 32'h8);         // cnt->9
    look("byte_offset_ignored", 32'h143, 1'b1, 1'b1, 32'h400, 32'h9);   // cnt->10

    // Another index is independent; top index boundary.
    upd(32'h13C, 1'b1, 32'h800);                                         // idx 15
    look("idx15_hit", 32'h13C, 1'b1, 1'b1, 32'h800, 32'hA);             // cnt->11
    look("idx0_still", 32'h140, 1'b1, 1'b1, 32'h400, 32'hB);            // cnt->12

    // Reset with pending update; outputs masked during reset.
    step("reset_pending", 1'b1, 1'b1, 32'h140, 1'b1, 32'h500, 1'b1, 32'h600,
         1'b0, 1'b1, 32'h0, 32'hC);
    look("after_reset_100", 32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
    look("after_reset_500", 32'h500, 1'b0, 1'b0, 32'h0, 32'h0);
    look("after_reset_140", 32'h140, 1'b0, 1'b1, 32'h0, 32'h0);

    step("idle", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
